// File: rtl/print_uart_tx.sv
// print_uart_tx: a character FIFO feeding a UART transmitter.
//
// Bytes pushed on wr_en_i/wr_data_i are queued in a DEPTH-entry FIFO and
// sent on tx_o. The format is one start bit, DATA_BITS data bits (LSB
// first), an optional even-parity bit and STOP_BITS stop bits. Each bit
// lasts clk_div_i+1 clocks. The divisor is sampled once per frame, when
// the frame's byte is popped from the FIFO.
//
// Ports:
//   wb_clk_i    clock, rising edge
//   wb_rst_i    asynchronous active-high reset
//   wr_en_i     push request
//   wr_data_i   character to push
//   clk_div_i   bit period minus one, in clocks
//   clr_ovf_i   clears overflow_o; a drop in the same cycle takes priority
//   full_o      FIFO holds DEPTH entries
//   count_o     number of FIFO entries
//   overflow_o  sticky; set when a push is dropped because the FIFO is full
//   busy_o      a frame is in progress
//   tx_o        serial line, idles high
module print_uart_tx #(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wr_en_i,
    input  logic [DATA_BITS-1:0]       wr_data_i,
    input  logic [DIV_W-1:0]           clk_div_i,
    input  logic                       clr_ovf_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       busy_o,
    output logic                       tx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // FIFO state
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic                 ovf_q;

    // Transmitter state
    state_t               state;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 tx_q;
    logic                 busy_q;

    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 last_stop;
    logic [DATA_BITS-1:0] head;

    assign full_o    = (count_q == CW'(DEPTH));
    assign push      = wr_en_i && !full_o;
    assign bit_done  = (cnt_q == '0);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign head      = mem[rd_ptr];

    // A pop happens either from IDLE or on the final cycle of the last stop
    // bit. The second case is what makes back-to-back frames gap-free.
    assign pop = (count_q != '0) &&
                 ((state == IDLE) || (state == STOP && bit_done && last_stop));

    // NOTE: the storage array has no reset. Reset zeroes the pointers and
    // the count, which makes every entry unreachable. Resetting the array
    // would only stop it mapping onto plain RAM.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // NOTE: all state registers use non-blocking assignments. Every block
    // then sees pre-edge values, independent of evaluation order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (wr_en_i && full_o) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (pop) begin
            // Load a new frame. The divisor is latched here, so a change
            // to clk_div_i mid-frame has no effect until the next pop.
            state    <= START;
            shift_q  <= head;
            parity_q <= ^head;
            div_q    <= clk_div_i;
            cnt_q    <= clk_div_i;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        cnt_q <= div_q;
                        tx_q  <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= div_q;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_q  <= parity_q;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                tx_q     <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        cnt_q    <= div_q;
                        tx_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            // FIFO is empty; a non-empty FIFO takes the pop path above.
                            state  <= IDLE;
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                            cnt_q    <= div_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign busy_o     = busy_q;
    assign tx_o       = tx_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Testbench for print_uart_tx.
// Three instances run in parallel: 8N1, 8E1 and 8N2, all DEPTH=16.
// Expected line waveforms are built from the frame format:
//   start=0, data LSB first, even parity, then stop ones,
// with each bit held for div+1 clocks.
module tb_print_uart_tx;

    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] wr_en;
    logic [NI-1:0] clr;
    logic [NI-1:0] full;
    logic [NI-1:0] busy;
    logic [NI-1:0] tx;
    logic [NI-1:0] ovf;
    logic [7:0]    wr_data [NI];
    logic [15:0]   clk_div [NI];
    logic [4:0]    cnt     [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    print_uart_tx #(.DEPTH(16), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1), .DIV_W(16)) dut_8n1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en_i(wr_en[0]), .wr_data_i(wr_data[0]),
        .clk_div_i(clk_div[0]), .clr_ovf_i(clr[0]), .full_o(full[0]), .count_o(cnt[0]),
        .overflow_o(ovf[0]), .busy_o(busy[0]), .tx_o(tx[0]));

    print_uart_tx #(.DEPTH(16), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1), .DIV_W(16)) dut_8e1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en_i(wr_en[1]), .wr_data_i(wr_data[1]),
        .clk_div_i(clk_div[1]), .clr_ovf_i(clr[1]), .full_o(full[1]), .count_o(cnt[1]),
        .overflow_o(ovf[1]), .busy_o(busy[1]), .tx_o(tx[1]));

    print_uart_tx #(.DEPTH(16), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2), .DIV_W(16)) dut_8n2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en_i(wr_en[2]), .wr_data_i(wr_data[2]),
        .clk_div_i(clk_div[2]), .clr_ovf_i(clr[2]), .full_o(full[2]), .count_o(cnt[2]),
        .overflow_o(ovf[2]), .busy_o(busy[2]), .tx_o(tx[2]));

    // One comparison: counts it, and counts and reports it if it failed.
    task automatic check(input bit ok, input string msg);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s", msg);
        end
    endtask

    function automatic int par_of(input int idx);
        return (idx == 1) ? 1 : 0;
    endfunction

    function automatic int stops_of(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    // Bit sequence of one frame, index 0 = start bit. Bits past the
    // data/parity positions are ones (stop bits).
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (par != 0) b[9] = ^d;
        return b;
    endfunction

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes one byte into an idle, empty instance, checks the push/pop
    // latency, then compares the tx and busy waveforms of the whole frame.
    task automatic single_frame(input int idx, input logic [7:0] data, input int div,
                                input bit chg_div, input string name);
        logic [127:0] exp_tx, obs_tx, exp_busy, obs_busy;
        logic [15:0]  fb;
        int           nbits, len;
        exp_tx = '0; obs_tx = '0; exp_busy = '0; obs_busy = '0;
        clk_div[idx] = 16'(div);
        wr_data[idx] = data;
        wr_en[idx]   = 1'b1;
        tick();
        wr_en[idx] = 1'b0;
        check(!(cnt[idx] !== 5'd1 || busy[idx] !== 1'b0),
              $sformatf("%s_push: count=%0d busy=%b, expected count=1 busy=0", name, cnt[idx], busy[idx]));
        tick();
        check(!(cnt[idx] !== 5'd0 || busy[idx] !== 1'b1 || tx[idx] !== 1'b0),
              $sformatf("%s_pop: count=%0d busy=%b tx=%b, expected 0 1 0", name, cnt[idx], busy[idx], tx[idx]));
        if (chg_div) clk_div[idx] = 16'($urandom_range(1, 7));
        fb    = frame_bits(data, par_of(idx));
        nbits = 9 + par_of(idx) + stops_of(idx);
        len   = nbits * (div + 1);
        for (int k = 0; k < len + 4; k++) begin
            exp_tx[k]   = (k < len) ? fb[k / (div + 1)] : 1'b1;
            exp_busy[k] = (k < len);
            obs_tx[k]   = tx[idx];
            obs_busy[k] = busy[idx];
            tick();
        end
        check(obs_tx === exp_tx,
              $sformatf("%s_tx: got %h expected %h", name, obs_tx, exp_tx));
        check(obs_busy === exp_busy,
              $sformatf("%s_busy: got %h expected %h", name, obs_busy, exp_busy));
        clk_div[idx] = 16'(div);
    endtask

    // Line-side UART receiver: finds the start bit, samples mid-bit.
    task automatic rx_byte(input int idx, input int div, output logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        b  = '0;
        ok = 1'b0;
        while (tx[idx] !== 1'b0 && waited < 3000) begin
            tick();
            waited++;
        end
        if (tx[idx] !== 1'b0) return;
        repeat ((div + 1) / 2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (div + 1) tick();
            b[i] = tx[idx];
        end
        repeat (div + 1) tick();
        ok = (tx[idx] === 1'b1);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        wr_en = '0;
        clr   = '0;
        for (int i = 0; i < NI; i++) begin
            wr_data[i] = 8'h00;
            clk_div[i] = 16'd3;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check({tx[i], busy[i], full[i], cnt[i], ovf[i]} === {1'b1, 1'b0, 1'b0, 5'd0, 1'b0},
                  $sformatf("reset_%0d: tx/busy/full/count/ovf=%b/%b/%b/%0d/%b, expected 1/0/0/0/0",
                            i, tx[i], busy[i], full[i], cnt[i], ovf[i]));
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_char();
        single_frame(0, 8'h41, 3, 1'b0, "char_41");
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_tx, obs_tx, obs_busy;
        logic [15:0]  fb1, fb2;
        logic [7:0]   rx1, rx2;
        logic [4:0]   c29, c30;
        exp_tx = '0; obs_tx = '0; obs_busy = '0; c29 = '0; c30 = '0;
        clk_div[0] = 16'd2;
        wr_data[0] = 8'h4F;
        wr_en[0]   = 1'b1;
        tick();
        check(cnt[0] === 5'd1,
              $sformatf("b2b_count_first: got %0d expected 1", cnt[0]));
        wr_data[0] = 8'h4B;
        tick();
        wr_en[0] = 1'b0;
        check(!(cnt[0] !== 5'd1 || busy[0] !== 1'b1 || tx[0] !== 1'b0),
              $sformatf("b2b_push_pop: count=%0d busy=%b tx=%b, expected 1 1 0", cnt[0], busy[0], tx[0]));
        fb1 = frame_bits(8'h4F, 0);
        fb2 = frame_bits(8'h4B, 0);
        for (int k = 0; k < 64; k++) begin
            exp_tx[k]   = (k < 30) ? fb1[k / 3] : (k < 60) ? fb2[(k - 30) / 3] : 1'b1;
            obs_tx[k]   = tx[0];
            obs_busy[k] = busy[0];
            if (k == 29) c29 = cnt[0];
            if (k == 30) c30 = cnt[0];
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rx1[i] = obs_tx[(1 + i) * 3 + 1];
            rx2[i] = obs_tx[30 + (1 + i) * 3 + 1];
        end
        check(obs_tx === exp_tx,
              $sformatf("b2b_tx: got %h expected %h", obs_tx, exp_tx));
        check({rx1, rx2} === 16'h4F4B,
              $sformatf("b2b_decode: got %h expected 4f4b (\"OK\")", {rx1, rx2}));
        check(!(obs_busy[59:0] !== {60{1'b1}} || obs_busy[63:60] !== 4'b0000),
              $sformatf("b2b_busy: got %h expected 60 ones then zeros", obs_busy));
        check(!(c29 !== 5'd1 || c30 !== 5'd0),
              $sformatf("b2b_count_drain: got %0d,%0d expected 1,0", c29, c30));
    endtask

    task automatic test_parity();
        single_frame(1, 8'h07, 2, 1'b0, "parity_07");
        single_frame(1, 8'h03, 2, 1'b0, "parity_03");
    endtask

    task automatic test_div0_stop2();
        single_frame(2, 8'hA5, 0, 1'b1, "div0_2stop");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            single_frame($urandom_range(0, NI - 1), 8'($urandom), $urandom_range(0, 4),
                         1'($urandom), "random");
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] got [17];
        logic [7:0] d;
        int         ngot, mcount, waited;
        bit         dropped;
        ngot = 0; mcount = 0; dropped = 1'b0;
        clk_div[0] = 16'd100;
        fork
            begin
                for (int i = 1; i <= 18; i++) begin
                    d          = 8'($urandom);
                    wr_data[0] = d;
                    wr_en[0]   = 1'b1;
                    tick();
                    if (mcount < 16) begin
                        exp_q.push_back(d);
                        mcount++;
                    end else begin
                        dropped = 1'b1;
                    end
                    if (i == 2) mcount--;  // first byte is popped one edge after its push
                    check(!(cnt[0] !== 5'(mcount) || full[0] !== 1'(mcount == 16)),
                          $sformatf("ovf_fill_%0d: count=%0d full=%b, expected %0d %b",
                                    i, cnt[0], full[0], mcount, mcount == 16));
                end
                wr_en[0] = 1'b0;
                check(!(ovf[0] !== 1'(dropped) || dropped !== 1'b1),
                      $sformatf("ovf_set: got %b expected 1", ovf[0]));
                wr_en[0] = 1'b1;
                clr[0]   = 1'b1;
                tick();
                wr_en[0] = 1'b0;
                clr[0]   = 1'b0;
                check(!(ovf[0] !== 1'b1 || cnt[0] !== 5'd16),
                      $sformatf("ovf_set_wins: ovf=%b count=%0d, expected 1 16", ovf[0], cnt[0]));
                clr[0] = 1'b1;
                tick();
                clr[0] = 1'b0;
                check(ovf[0] === 1'b0,
                      $sformatf("ovf_clear: got %b expected 0", ovf[0]));
            end
            begin
                // 17 pushes are accepted: 16 to fill plus the one popped.
                for (int j = 0; j < 17; j++) begin
                    bit ok;
                    rx_byte(0, 100, got[j], ok);
                    check(ok, $sformatf("ovf_rx_frame_%0d: no valid frame received", j));
                    if (!ok) break;
                    ngot++;
                end
            end
        join
        check(ngot == exp_q.size(),
              $sformatf("ovf_rx_count: got %0d expected %0d", ngot, exp_q.size()));
        for (int j = 0; j < ngot && j < exp_q.size(); j++) begin
            check(got[j] === exp_q[j],
                  $sformatf("ovf_rx_byte_%0d: got %h expected %h", j, got[j], exp_q[j]));
        end
        waited = 0;
        while (busy[0] !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        check(!(busy[0] !== 1'b0 || cnt[0] !== 5'd0),
              $sformatf("ovf_drain: busy=%b count=%0d, expected 0 0", busy[0], cnt[0]));
    endtask

    task automatic test_reset_midframe();
        bit active;
        active     = 1'b0;
        clk_div[0] = 16'd3;
        for (int i = 0; i < 3; i++) begin
            wr_data[0] = 8'($urandom);
            wr_en[0]   = 1'b1;
            tick();
        end
        wr_en[0] = 1'b0;
        repeat (6) tick();  // start bit done; now inside the data bits
        check(!(busy[0] !== 1'b1 || cnt[0] !== 5'd2),
              $sformatf("rstmid_pre: busy=%b count=%0d, expected 1 2", busy[0], cnt[0]));
        #2;
        rst = 1'b1;
        #1;
        check({tx[0], busy[0], cnt[0], full[0]} === {1'b1, 1'b0, 5'd0, 1'b0},
              $sformatf("rstmid_async: tx/busy/count/full=%b/%b/%0d/%b, expected 1/0/0/0",
                        tx[0], busy[0], cnt[0], full[0]));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 5'd0) active = 1'b1;
        end
        check(active === 1'b0, "rstmid_quiet: activity seen after reset, expected none");
        single_frame(0, 8'($urandom), 1, 1'b0, "post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_char();
        test_back_to_back();
        test_parity();
        test_div0_stop2();
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/print_uart_tx.md
# print_uart_tx

Parametrised character-output block for the Elpis user project: the core's print path pushes bytes into an internal FIFO, and a UART transmitter serialises them onto a user GPIO (mprj_io[6]) for the testbench UART monitor. It extends single-byte print output with configurable FIFO depth, data width, parity, stop bits and run-time baud divisor. It also provides back-to-back framing and sticky overflow detection. It sits between the core's print/LA strobe and the pad driving `uart_tx`.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- DATA_BITS, 8: bits per character, 5 to 8.
- PARITY_EN, 0: 1 appends an even-parity bit after the data bits.
- STOP_BITS, 1: 1 or 2 stop bits.
- DIV_W, 16: width of the baud divisor.

Ports:
- wb_clk_i  in  1  single clock; all logic is on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  push request.
- wr_data_i  in  DATA_BITS  character to push.
- clk_div_i  in  DIV_W  bit period minus one, in clocks.
- clr_ovf_i  in  1  clears overflow_o.
- full_o  out  1  FIFO holds DEPTH entries.
- count_o  out  $clog2(DEPTH+1)  number of FIFO entries.
- overflow_o  out  1  sticky flag; set when a push is dropped.
- busy_o  out  1  a frame is in progress.
- tx_o  out  1  serial line; idles high.

## Operation
- FIFO:
  - A push is accepted when wr_en_i=1 and full_o=0. The data is stored at wr_ptr, and wr_ptr and count_o update at the edge.
  - Both pointers wrap modulo DEPTH.
  - full_o and count_o derive from registered state only.
- A push with full_o=1 is dropped and sets overflow_o at that edge. This holds even if a pop happens in the same cycle.
- Simultaneous accepted push and pop leave count_o unchanged.
- overflow_o clears on clr_ovf_i=1. If a drop occurs in the same cycle, the set wins.
- Transmitter FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1 and busy_o=0. If count_o>0, the next edge pops the head into the shift register, latches clk_div_i into div_q, clears the bit counter and enters START.
  - START: tx_o=0 for div_q+1 cycles, then enters DATA.
  - DATA: tx_o = shift[0], sent LSB first. Each bit lasts div_q+1 cycles. After DATA_BITS bits the FSM enters PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: tx_o = XOR of the data bits (even parity), for one bit period.
  - STOP: tx_o=1 for STOP_BITS bit periods. At the end, if count_o>0 the FSM pops and enters START directly, with no idle gap. Otherwise it enters IDLE.
- busy_o=1 in every state except IDLE.
- A change of clk_div_i mid-frame has no effect until the next pop.
- Bit timing: a down-counter is loaded with div_q and a bit advances when it reaches 0. clk_div_i=0 gives 1 clock per bit.

## Timing
- Reset (asynchronous, immediate):
  - tx_o=1, busy_o=0, full_o=0, count_o=0, overflow_o=0.
  - Pointers are zeroed, the FIFO is flushed and the state returns to IDLE.
  - A frame in progress is truncated with the line high. Characters in the FIFO are discarded.
- Latency, push into an empty FIFO while IDLE:
  - The push is accepted at edge N, so count_o=1 after N.
  - The pop occurs at edge N+1, after which tx_o=0 and busy_o=1.
  - count_o returns to 0 after edge N+1.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × (div_q+1) clocks.
- Back-to-back: the start bit of the next frame follows the final stop-bit cycle directly.
- No combinational path from any input to any output.

## Test plan
- Single char, clk_div_i=3, 8N1: push 0x41. tx_o is low for 4 clocks starting the cycle after the pop. The bits then follow as 1,0,0,0,0,0,1,0, each 4 clocks, then the stop bit. busy_o is high for exactly 40 clocks.
- Back-to-back: push 'O' (0x4F) and 'K' (0x4B) on consecutive cycles. The testbench UART decodes "OK". There is no idle cycle between the first stop bit and the second start bit. count_o reads 1, then 0.
- Overflow, DEPTH=16, clk_div_i=100: push 18 bytes in 18 consecutive cycles.
  - full_o asserts once count_o reaches 16. At least one push is dropped and overflow_o=1.
  - Transmitted bytes are the first accepted ones, in order.
  - clr_ovf_i clears overflow_o.
- Parity, PARITY_EN=1: push 0x07, then 0x03. The parity bits are 1 and 0. Frame length is 11 bit periods.
- Reset mid-frame: assert wb_rst_i during DATA with 3 bytes queued. tx_o goes 1 and busy_o goes 0 immediately, and count_o=0. After release, nothing is transmitted until a new push.
- clk_div_i=0 with 2 stop bits: push 0xA5. The frame is 11 clocks and every bit lasts 1 clock. Changing clk_div_i mid-frame does not alter that frame.
